write_fifo_ctrl: RTL
====================

# write_fifo_ctrl

Write-side controller for the synchronous UART FIFO, the counterpart of the read-side pointer block. It accepts write requests from the producer (UART RX deserializer or CPU TX path), drives the storage array's write strobe/address/data, and maintains the extended write pointer consumed by the read side. It derives full, level, almost-full and sticky overflow status from its own pointer and the read side's pointer, and tracks a high-watermark for diagnostics.

## Interface
- ADDR_WIDTH, 4, address bits; depth = 2^ADDR_WIDTH entries
- DATA_WIDTH, 8, data word width
- AF_THRESH, 12, almost-full threshold in entries; legal range 1..2^ADDR_WIDTH

- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request for current cycle
- wr_data  in  DATA_WIDTH  write word
- rd_ptr  in  ADDR_WIDTH+1  read-side extended pointer
- ovf_clr  in  1  clears overflow flag, drop counter and high-watermark
- wr_ptr  out  ADDR_WIDTH+1  extended write pointer (registered)
- mem_we  out  1  storage write strobe
- mem_addr  out  ADDR_WIDTH  storage write address = wr_ptr[ADDR_WIDTH-1:0]
- mem_wdata  out  DATA_WIDTH  = wr_data
- full  out  1  FIFO full
- almost_full  out  1  level >= AF_THRESH
- level  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH
- overflow  out  1  sticky: a write was dropped
- drop_cnt  out  8  saturating count of dropped writes
- hwm  out  ADDR_WIDTH+1  maximum level seen since reset/clear

## Operation
- Accept = wr_en && !full. On accept: mem_we=1, wr_ptr increments by 1 at next edge, wrapping modulo 2^(ADDR_WIDTH+1).
- mem_we, mem_addr, mem_wdata combinational from wr_en, full, wr_ptr, wr_data.
- level = wr_ptr - rd_ptr, ADDR_WIDTH+1-bit unsigned (wrap-safe).
- full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]); combinational.
- Drop = wr_en && full: no strobe, pointer held, overflow set next edge, drop_cnt increments and saturates at 255.
- ovf_clr: at next edge overflow=0, drop_cnt=0, hwm=current level. Clear and drop in the same cycle: clear wins for overflow/drop_cnt (drop not recorded).
- hwm: registered; updates to level when level > hwm.
- rd_ptr advancing in the same cycle as a write: both pointers update independently; full re-evaluated next cycle. Writes in a cycle where full=1 are dropped even if the read side pops simultaneously.

## Timing
- Reset values: wr_ptr=0, overflow=0, drop_cnt=0, hwm=0; hence mem_addr=0, level=0 (with rd_ptr=0), full=0, almost_full=0, mem_we=0 unless wr_en.
- Reset dominates all inputs in its cycle; reset mid-stream discards pointer state (read side must be reset in the same cycle).
- Accept-to-pointer latency: 1 cycle; full/level/almost_full reflect new pointer in the following cycle.
- overflow, drop_cnt, hwm: 1 cycle after the causing event.
- No ready/valid back-pressure beyond full; producer samples full in the same cycle as wr_en.

## Configuration
- WR_FIFO_ALMOST_FULL_EN defined: almost_full computed as level >= AF_THRESH (combinational from level).
- Undefined: almost_full tied to 0, AF_THRESH unused, threshold comparator not synthesized; all other behaviour unchanged.

## Test plan
- Reset then 16 writes (0x00..0x0F), rd_ptr=0 -> mem_addr 0..15, wr_ptr=16 (0b10000), full=1, level=16, hwm=16.
- Full, wr_en with 0xAA for 3 cycles -> mem_we=0, wr_ptr held, overflow=1, drop_cnt=3; ovf_clr -> overflow=0, drop_cnt=0 next cycle.
- Wrap: rd_ptr=30, wr_ptr=30, write 4 words -> wr_ptr=2, mem_addr 14,15,0,1, level=4, full=0.
- Macro defined, AF_THRESH=12: write 11 -> almost_full=0; 12th write -> almost_full=1 next cycle; macro undefined -> stays 0.
- Full with rd_ptr advancing and wr_en same cycle -> write dropped, drop_cnt=1; next cycle full=0, write accepted.
- 300 drops -> drop_cnt=255; rst asserted mid-burst -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/write_fifo_ctrl_if.sv
// Write-side FIFO controller bus: producer request, read-side pointer,
// storage write port and status outputs.
interface write_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic [7:0]            drop_cnt;
    logic [ADDR_WIDTH:0]   hwm;

    // Controller side
    modport slave (
        input  wr_en, wr_data, rd_ptr, ovf_clr,
        output wr_ptr, mem_we, mem_addr, mem_wdata, full, almost_full,
               level, overflow, drop_cnt, hwm
    );

    // Producer / read-side / storage side
    modport master (
        output wr_en, wr_data, rd_ptr, ovf_clr,
        input  wr_ptr, mem_we, mem_addr, mem_wdata, full, almost_full,
               level, overflow, drop_cnt, hwm
    );
endinterface

// File: rtl/write_fifo_ctrl.sv
// Write-side controller for the synchronous UART FIFO.
// Owns the extended write pointer, drives the storage write port and derives
// full / level / almost-full / overflow / drop count / high-watermark status.
// Optional feature macro: WR_FIFO_ALMOST_FULL_EN enables the almost-full
// comparator; without it almost_full is tied low.
module write_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 12
) (
    input  logic              clk,
    input  logic              rst,
    write_fifo_ctrl_if.slave  bus
);
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0] hwm_q,      hwm_d;

    logic             full;
    logic             accept;
    logic             drop;
    logic [PTR_W-1:0] level;

    // Occupancy and full flag from the two extended pointers
    always_comb begin
        level  = wr_ptr_q - bus.rd_ptr;
        full   = (wr_ptr_q[ADDR_WIDTH] != bus.rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == bus.rd_ptr[ADDR_WIDTH-1:0]);
        accept = bus.wr_en && !full;
        drop   = bus.wr_en && full;
    end

    // Next-state: pointer advance, sticky overflow, saturating drops, watermark
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        hwm_d      = hwm_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // A clear in the same cycle as a drop wins; the drop is not recorded
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
            hwm_d      = level;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            if (level > hwm_q) begin
                hwm_d = level;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            hwm_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            hwm_q      <= hwm_d;
        end
    end

`ifdef WR_FIFO_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);

    // Almost-full threshold comparator
    always_comb begin
        bus.almost_full = (level >= AF_LVL);
    end
`else
    // Threshold is only referenced here so the parameter stays in use
    logic unused_af_thresh;
    assign unused_af_thresh = (AF_THRESH > 0);

    // Almost-full disabled in this build
    always_comb begin
        bus.almost_full = 1'b0;
    end
`endif

    // Output drive: storage write port is combinational, status mirrors state
    always_comb begin
        bus.mem_we    = accept;
        bus.mem_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
        bus.mem_wdata = bus.wr_data;
        bus.wr_ptr    = wr_ptr_q;
        bus.full      = full;
        bus.level     = level;
        bus.overflow  = overflow_q;
        bus.drop_cnt  = drop_cnt_q;
        bus.hwm       = hwm_q;
    end

endmodule
